// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the microcode bootstrap loader
// Contents:
//   BOOT_BYTE_WIDTH  width of a boot byte, of the SRAM data lane and of the checksum
//   boot_state_t     loader states, also reused as the write strobe sequencer phase
package boot_pkg;

  localparam int BOOT_BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    FETCH,
    SETUP,
    WRITE,
    HOLD,
    CHECK,
    DONE,
    ERROR
  } boot_state_t;

endpackage

// File: rtl/sram_write_strobe.sv
// rtl/sram_write_strobe.sv - SETUP/WRITE/HOLD sequencer producing the active-low SRAM write strobe
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       one-cycle request; the next cycle is the setup cycle
//   n_we        registered active-low write strobe, low for WE_PULSE cycles
//   pulse_last  high in the final low cycle of the strobe
//   done        high during the hold cycle that follows the strobe
module sram_write_strobe
  import boot_pkg::*;
#(
  parameter int WE_PULSE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic n_we,
  output logic pulse_last,
  output logic done
);

  localparam int CW = (WE_PULSE > 1) ? $clog2(WE_PULSE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WE_PULSE - 1);

  // FETCH doubles as the idle phase of the sequencer.
  boot_state_t    phase;
  logic [CW-1:0]  pulse_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= FETCH;
      pulse_cnt <= '0;
      n_we      <= 1'b1;
    end else begin
      case (phase)
        FETCH: begin
          if (start) phase <= SETUP;
        end
        SETUP: begin
          phase     <= WRITE;
          n_we      <= 1'b0;
          pulse_cnt <= '0;
        end
        WRITE: begin
          if (pulse_cnt == LAST_CNT) begin
            phase <= HOLD;
            n_we  <= 1'b1;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        HOLD: begin
          phase <= FETCH;
        end
        default: begin
          phase <= FETCH;
          n_we  <= 1'b1;
        end
      endcase
    end
  end

  assign pulse_last = (phase == WRITE) && (pulse_cnt == LAST_CNT);
  assign done       = (phase == HOLD);

endmodule

// File: rtl/microcode_bootstrap_loader.sv
// rtl/microcode_bootstrap_loader.sv - loads the microcode SRAM from a byte stream and verifies its checksum
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   SRC_VALID/DATA  boot byte stream from the boot source
//   SRC_READY       loader accepts SRC_DATA this cycle
//   BOOTSTRAP_ADDR  SRAM write address
//   BOOTSTRAP_DATA  SRAM write data
//   BOOTSTRAP_N_WE  active-low SRAM write strobe
//   N_BOOTED        low once every byte is written and the checksum matches
//   BOOT_ERR        sticky checksum mismatch flag
module microcode_bootstrap_loader
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096,
  parameter int WE_PULSE   = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       SRC_VALID,
  input  logic [BOOT_BYTE_WIDTH-1:0] SRC_DATA,
  output logic                       SRC_READY,
  output logic [ADDR_WIDTH-1:0]      BOOTSTRAP_ADDR,
  output logic [BOOT_BYTE_WIDTH-1:0] BOOTSTRAP_DATA,
  output logic                       BOOTSTRAP_N_WE,
  output logic                       N_BOOTED,
  output logic                       BOOT_ERR
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  boot_state_t                state;
  logic [BOOT_BYTE_WIDTH-1:0] acc;
  logic [BOOT_BYTE_WIDTH-1:0] sum_next;
  logic                       xfer;
  logic                       we_last;
  logic                       we_done;

  assign xfer     = SRC_VALID && SRC_READY;
  assign sum_next = acc + SRC_DATA;

  sram_write_strobe #(
    .WE_PULSE(WE_PULSE)
  ) u_strobe (
    .clk        (CLK),
    .rst        (RST),
    .start      ((state == FETCH) && xfer),
    .n_we       (BOOTSTRAP_N_WE),
    .pulse_last (we_last),
    .done       (we_done)
  );

  // SRC_READY is registered, so it is raised on the edge that enters FETCH or
  // CHECK; this keeps the accept-to-accept spacing at WE_PULSE+3 cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= FETCH;
      SRC_READY      <= 1'b0;
      BOOTSTRAP_ADDR <= '0;
      BOOTSTRAP_DATA <= '0;
      N_BOOTED       <= 1'b1;
      BOOT_ERR       <= 1'b0;
      acc            <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (xfer) begin
            BOOTSTRAP_DATA <= SRC_DATA;
            acc            <= sum_next;
            SRC_READY      <= 1'b0;
            state          <= SETUP;
          end else begin
            SRC_READY <= 1'b1;
          end
        end
        SETUP: state <= WRITE;
        WRITE: begin
          if (we_last) state <= HOLD;
        end
        HOLD: begin
          if (we_done) begin
            SRC_READY <= 1'b1;
            if (BOOTSTRAP_ADDR == LAST_ADDR) begin
              state <= CHECK;
            end else begin
              BOOTSTRAP_ADDR <= BOOTSTRAP_ADDR + ADDR_WIDTH'(1);
              state          <= FETCH;
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            SRC_READY <= 1'b0;
            acc       <= sum_next;
            if (sum_next == '0) begin
              state          <= DONE;
              N_BOOTED       <= 1'b0;
              BOOTSTRAP_ADDR <= '0;
              BOOTSTRAP_DATA <= '0;
            end else begin
              state    <= ERROR;
              BOOT_ERR <= 1'b1;
            end
          end else begin
            SRC_READY <= 1'b1;
          end
        end
        DONE:  SRC_READY <= 1'b0;
        ERROR: SRC_READY <= 1'b0;
        default: begin
          state     <= ERROR;
          SRC_READY <= 1'b0;
          BOOT_ERR  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_bootstrap_loader.sv
// tb/tb_microcode_bootstrap_loader.sv - self-checking bench for microcode_bootstrap_loader
module tb_microcode_bootstrap_loader;

  typedef logic [7:0] byte_q_t [$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Instance A: DEPTH=4, WE_PULSE=2
  logic        a_rst = 1'b1, a_valid = 1'b0;
  logic [7:0]  a_data = 8'h00;
  logic        a_ready, a_nwe, a_nbooted, a_err;
  logic [11:0] a_addr;
  logic [7:0]  a_wdata;

  microcode_bootstrap_loader #(.ADDR_WIDTH(12), .DEPTH(4), .WE_PULSE(2)) dut_a (
    .CLK(clk), .RST(a_rst), .SRC_VALID(a_valid), .SRC_DATA(a_data), .SRC_READY(a_ready),
    .BOOTSTRAP_ADDR(a_addr), .BOOTSTRAP_DATA(a_wdata), .BOOTSTRAP_N_WE(a_nwe),
    .N_BOOTED(a_nbooted), .BOOT_ERR(a_err));

  // Instance B: DEPTH=1, WE_PULSE=1
  logic        b_rst = 1'b1, b_valid = 1'b0;
  logic [7:0]  b_data = 8'h00;
  logic        b_ready, b_nwe, b_nbooted, b_err;
  logic [11:0] b_addr;
  logic [7:0]  b_wdata;

  microcode_bootstrap_loader #(.ADDR_WIDTH(12), .DEPTH(1), .WE_PULSE(1)) dut_b (
    .CLK(clk), .RST(b_rst), .SRC_VALID(b_valid), .SRC_DATA(b_data), .SRC_READY(b_ready),
    .BOOTSTRAP_ADDR(b_addr), .BOOTSTRAP_DATA(b_wdata), .BOOTSTRAP_N_WE(b_nwe),
    .N_BOOTED(b_nbooted), .BOOT_ERR(b_err));

  // SRAM model for A: a byte is committed when the strobe rises.
  logic [7:0]  img [0:3];
  int          wlog_addr [$];
  int          wlog_data [$];
  int          acc_cyc [$];
  logic        prev_nwe = 1'b1;
  logic [11:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;
  logic        in_pulse = 1'b0;
  int          plen = 0;
  logic [11:0] w_addr = '0;
  logic [7:0]  w_data = '0;

  always @(negedge clk) begin
    prev_nwe  <= a_nwe;
    prev_addr <= a_addr;
    prev_data <= a_wdata;
    if (a_valid && a_ready && !a_rst) acc_cyc.push_back(cyc);
    if (a_rst) begin
      in_pulse <= 1'b0;
    end else if (prev_nwe && !a_nwe) begin
      check_eq("setup_addr", int'(a_addr), int'(prev_addr));
      check_eq("setup_data", int'(a_wdata), int'(prev_data));
      in_pulse <= 1'b1;
      plen     <= 1;
      w_addr   <= a_addr;
      w_data   <= a_wdata;
    end else if (!a_nwe && in_pulse) begin
      plen <= plen + 1;
      if (a_addr !== w_addr || a_wdata !== w_data)
        check_eq("pulse_stable", 1, 0);
    end else if (a_nwe && in_pulse) begin
      check_eq("pulse_len", plen, 2);
      check_eq("hold_addr", int'(a_addr), int'(w_addr));
      check_eq("hold_data", int'(a_wdata), int'(w_data));
      img[w_addr[1:0]] <= w_data;
      wlog_addr.push_back(int'(w_addr));
      wlog_data.push_back(int'(w_data));
      in_pulse <= 1'b0;
    end
  end

  // Strobe observer for B.
  logic        b_prev = 1'b1;
  int          b_falls = 0;
  int          b_low = 0;
  logic [11:0] b_cap_addr = '0;
  logic [7:0]  b_cap_data = '0;

  always @(negedge clk) begin
    b_prev <= b_nwe;
    if (!b_nwe) b_low <= b_low + 1;
    if (b_prev && !b_nwe) begin
      b_falls    <= b_falls + 1;
      b_cap_addr <= b_addr;
      b_cap_data <= b_wdata;
    end
  end

  function automatic logic [7:0] good_sum(input byte_q_t q);
    int s = 0;
    foreach (q[i]) s += int'(q[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  // Offers bytes in order; a byte once offered stays valid until taken.
  task automatic send_a(input byte_q_t q, input bit gapped);
    int  i = 0;
    int  budget = 3000;
    bit  x;
    bit  hold = 1'b0;
    while (i < q.size() && budget > 0) begin
      if (!gapped || hold || $urandom_range(0, 2) != 0) begin
        a_valid = 1'b1;
        a_data  = q[i];
      end else begin
        a_valid = 1'b0;
        a_data  = 8'($urandom);
      end
      @(negedge clk);
      x = a_valid && a_ready;
      hold = a_valid && !x;
      @(posedge clk); #1;
      if (x) i++;
      budget--;
    end
    a_valid = 1'b0;
    if (i < q.size()) check_eq("a_timeout", i, q.size());
  endtask

  task automatic send_b(input logic [7:0] v);
    int budget = 100;
    bit x = 1'b0;
    b_valid = 1'b1;
    b_data  = v;
    while (!x && budget > 0) begin
      @(negedge clk);
      x = b_ready;
      @(posedge clk); #1;
      budget--;
    end
    b_valid = 1'b0;
    if (!x) check_eq("b_timeout", 0, 1);
  endtask

  task automatic reset_a();
    a_rst = 1'b1;
    a_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    a_rst = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int base, input byte_q_t q);
    check_eq({tag, "_nwrites"}, wlog_addr.size() - base, q.size());
    for (int k = 0; k < q.size() && base + k < wlog_addr.size(); k++) begin
      check_eq({tag, "_waddr"}, wlog_addr[base + k], k);
      check_eq({tag, "_wdata"}, wlog_data[base + k], int'(q[k]));
      check_eq({tag, "_img"}, int'(img[k]), int'(q[k]));
    end
  endtask

  initial begin
    byte_q_t pay;
    byte_q_t full;
    int wb, ab, errs, budget;

    @(posedge clk); @(posedge clk); #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
    check_eq("rst_ready", int'(a_ready), 0);
    check_eq("rst_addr", int'(a_addr), 0);
    check_eq("rst_data", int'(a_wdata), 0);
    check_eq("rst_nwe", int'(a_nwe), 1);
    check_eq("rst_nbooted", int'(a_nbooted), 1);
    check_eq("rst_err", int'(a_err), 0);
    check_eq("rst_b_nbooted", int'(b_nbooted), 1);

    // Fixed stream, good checksum, source always valid.
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    full = pay; full.push_back(8'h56);
    wb = wlog_addr.size(); ab = acc_cyc.size();
    send_a(full, 1'b0);
    check_eq("t1_nbooted", int'(a_nbooted), 0);
    check_eq("t1_err", int'(a_err), 0);
    check_eq("t1_ready", int'(a_ready), 0);
    check_eq("t1_done_addr", int'(a_addr), 0);
    check_eq("t1_done_data", int'(a_wdata), 0);
    check_writes("t1", wb, pay);
    check_eq("t1_naccept", acc_cyc.size() - ab, 5);
    for (int k = ab + 1; k < acc_cyc.size(); k++)
      check_eq("t1_spacing", acc_cyc[k] - acc_cyc[k - 1], 5);

    // Same stream, bad checksum.
    reset_a();
    full[4] = 8'h57;
    wb = wlog_addr.size();
    send_a(full, 1'b0);
    check_eq("t2_err", int'(a_err), 1);
    errs = 0;
    for (int k = 0; k < 100; k++) begin
      a_valid = 1'b1;
      a_data  = 8'($urandom);
      @(posedge clk); #1;
      if (a_err !== 1'b1 || a_nbooted !== 1'b1 || a_ready !== 1'b0 || a_nwe !== 1'b1) errs++;
    end
    a_valid = 1'b0;
    check_eq("t2_err_hold", errs, 0);
    check_eq("t2_nwrites", wlog_addr.size() - wb, 4);

    // Gapped random streams.
    for (int it = 0; it < 3; it++) begin
      reset_a();
      pay = {};
      for (int k = 0; k < 4; k++) pay.push_back(8'($urandom));
      full = pay; full.push_back(good_sum(pay));
      wb = wlog_addr.size();
      send_a(full, 1'b1);
      check_eq("t3_nbooted", int'(a_nbooted), 0);
      check_writes("t3", wb, pay);
    end

    // Reset during the second byte's write pulse, then reload.
    reset_a();
    pay = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    full = pay; full.push_back(good_sum(pay));
    send_a('{pay[0]}, 1'b0);
    send_a('{pay[1]}, 1'b0);
    budget = 20;
    while (a_nwe !== 1'b0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check_eq("t4_in_pulse", int'(a_nwe), 0);
    a_rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t4_nwe_rst", int'(a_nwe), 1);
    check_eq("t4_addr_rst", int'(a_addr), 0);
    a_rst = 1'b0;
    wb = wlog_addr.size();
    send_a(full, 1'b0);
    check_eq("t4_nbooted", int'(a_nbooted), 0);
    check_writes("t4", wb, pay);

    // DEPTH=1, WE_PULSE=1.
    send_b(8'hFF);
    send_b(8'h01);
    check_eq("t5_nbooted", int'(b_nbooted), 0);
    check_eq("t5_err", int'(b_err), 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_falls", b_falls, 1);
    check_eq("t5_low", b_low, 1);
    check_eq("t5_addr", int'(b_cap_addr), 0);
    check_eq("t5_data", int'(b_cap_data), 255);
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      b_valid = 1'($urandom);
      b_data  = 8'($urandom);
      @(posedge clk); #1;
      if (b_ready !== 1'b0 || b_nbooted !== 1'b0) errs++;
    end
    b_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_after_done", errs, 0);
    check_eq("t5_falls_after", b_falls, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
